// File: rtl/rv0_rf_mp.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining RV0_RF_BYPASS_EN.
module rv0_rf_mp #(
    parameter  int unsigned XLEN    = 32,
    parameter  int unsigned RVI     = 1,
    parameter  int unsigned NR      = 2,
    parameter  int unsigned NW      = 1,
    localparam int unsigned REG_CNT = (RVI != 0) ? 32 : 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NR*5-1:0]      raddr_i,
    output logic [NR*XLEN-1:0]   rdata_o,
    output logic [NR-1:0]        rbusy_o,
    input  logic [NW-1:0]        we_i,
    input  logic [NW*5-1:0]      waddr_i,
    input  logic [NW*XLEN-1:0]   wdata_i,
    input  logic                 rsv_i,
    input  logic [4:0]           rsv_addr_i,
    input  logic                 flush_i,
    output logic [REG_CNT-1:0]   busy_o
);

    // x0 has no storage; it reads as zero through the read mux default.
    logic [XLEN-1:0]    regs_q [1:REG_CNT-1];
    logic [XLEN-1:0]    regs_d [1:REG_CNT-1];
    logic [REG_CNT-1:0] busy_q;
    logic [REG_CNT-1:0] busy_d;
    logic [REG_CNT-1:0] wr_rel;

    // Addresses are matched against each register index, so x0 and out-of-range
    // addresses never hit and need no separate validity check.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        wr_rel = '0;
        for (int unsigned r = 1; r < REG_CNT; r++) begin
            for (int unsigned j = 0; j < NW; j++) begin
                if (we_i[j] && (waddr_i[5*j +: 5] == 5'(r))) begin
                    regs_d[r] = wdata_i[XLEN*j +: XLEN];
                    wr_rel[r] = 1'b1;
                end
            end
            if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (rsv_i && (rsv_addr_i == 5'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wr_rel[r]) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned r = 1; r < REG_CNT; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

`ifdef RV0_RF_BYPASS_EN
    logic [NR-1:0] byp_hit;
`endif

    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
`ifdef RV0_RF_BYPASS_EN
        byp_hit = '0;
`endif
        for (int unsigned k = 0; k < NR; k++) begin
            for (int unsigned r = 1; r < REG_CNT; r++) begin
                if (raddr_i[5*k +: 5] == 5'(r)) begin
                    rdata_o[XLEN*k +: XLEN] = regs_q[r];
                    rbusy_o[k]              = busy_q[r];
                end
            end
`ifdef RV0_RF_BYPASS_EN
            // Gated by rst_ni so outputs stay zero while reset is asserted.
            for (int unsigned j = 0; j < NW; j++) begin
                if (rst_ni && we_i[j] && (raddr_i[5*k +: 5] != 5'd0)
                    && (32'(raddr_i[5*k +: 5]) < REG_CNT)
                    && (raddr_i[5*k +: 5] == waddr_i[5*j +: 5])) begin
                    rdata_o[XLEN*k +: XLEN] = wdata_i[XLEN*j +: XLEN];
                    byp_hit[k]              = 1'b1;
                end
            end
            if (byp_hit[k] && !(rsv_i && !flush_i && (rsv_addr_i == raddr_i[5*k +: 5]))) begin
                rbusy_o[k] = 1'b0;
            end
`endif
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_rv0_rf_mp.sv
// Directed bench for rv0_rf_mp: a 32-reg dual-write instance and a 16-reg (RV32E) instance.
module tb_rv0_rf_mp;

`ifdef RV0_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;

    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic [1:0]  a_we;
    logic [9:0]  a_waddr;
    logic [63:0] a_wdata;
    logic        a_rsv;
    logic [4:0]  a_rsv_addr;
    logic        a_flush;
    logic [31:0] a_busy;

    logic [4:0]  b_raddr;
    logic [31:0] b_rdata;
    logic [0:0]  b_rbusy;
    logic [0:0]  b_we;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        b_rsv;
    logic [4:0]  b_rsv_addr;
    logic        b_flush;
    logic [15:0] b_busy;

    int n_cmp = 0;
    int n_err = 0;

    rv0_rf_mp #(.XLEN(32), .RVI(1), .NR(2), .NW(2)) u_dut_a (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .raddr_i    (a_raddr),
        .rdata_o    (a_rdata),
        .rbusy_o    (a_rbusy),
        .we_i       (a_we),
        .waddr_i    (a_waddr),
        .wdata_i    (a_wdata),
        .rsv_i      (a_rsv),
        .rsv_addr_i (a_rsv_addr),
        .flush_i    (a_flush),
        .busy_o     (a_busy)
    );

    rv0_rf_mp #(.XLEN(32), .RVI(0), .NR(1), .NW(1)) u_dut_b (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .raddr_i    (b_raddr),
        .rdata_o    (b_rdata),
        .rbusy_o    (b_rbusy),
        .we_i       (b_we),
        .waddr_i    (b_waddr),
        .wdata_i    (b_wdata),
        .rsv_i      (b_rsv),
        .rsv_addr_i (b_rsv_addr),
        .flush_i    (b_flush),
        .busy_o     (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_we = '0; a_waddr = '0; a_wdata = '0;
        a_rsv = 1'b0; a_rsv_addr = '0; a_flush = 1'b0;
    endtask

    task automatic idle_b();
        b_we = '0; b_waddr = '0; b_wdata = '0;
        b_rsv = 1'b0; b_rsv_addr = '0; b_flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_raddr = '0; b_raddr = '0;
        idle_a(); idle_b();

        // Outputs while in reset
        #3;
        a_raddr = {5'd5, 5'd1};
        b_raddr = 5'd3;
        #1;
        chk("rst_rdata_a", a_rdata, 64'h0);
        chk("rst_rbusy_a", 64'(a_rbusy), 64'h0);
        chk("rst_busy_a",  64'(a_busy), 64'h0);
        chk("rst_busy_b",  64'(b_busy), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 1; i < 32; i++) begin
            a_raddr = {5'(i), 5'(32 - i)};
            #1;
            chk("rd_init", a_rdata, 64'h0);
        end
        chk("busy_init", 64'(a_busy), 64'h0);

        // x0 writes are dropped
        a_we = 2'b01; a_waddr = {5'd0, 5'd0}; a_wdata = {32'h0, 32'hDEADBEEF};
        a_raddr = {5'd0, 5'd0};
        #1;
        chk("x0_same", a_rdata, 64'h0);
        tick(); idle_a(); #1;
        chk("x0_next", a_rdata, 64'h0);

        // Same-address dual write: port 1 wins
        a_we = 2'b11; a_waddr = {5'd5, 5'd5}; a_wdata = {32'h22222222, 32'h11111111};
        tick(); idle_a();
        a_raddr = {5'd5, 5'd5};
        #1;
        chk("ww_prio", a_rdata, {32'h22222222, 32'h22222222});
        chk("ww_busy", 64'(a_busy), 64'h0);

        a_we = 2'b11; a_waddr = {5'd8, 5'd6}; a_wdata = {32'h00000088, 32'h00000066};
        tick(); idle_a();
        a_raddr = {5'd8, 5'd6};
        #1;
        chk("ww_dist", a_rdata, {32'h00000088, 32'h00000066});

        // Reserve x7, later release by write
        a_rsv = 1'b1; a_rsv_addr = 5'd7; a_raddr = {5'd7, 5'd7};
        #1;
        chk("rsv_pre_rbusy", 64'(a_rbusy), 64'h0);
        chk("rsv_pre_busy",  64'(a_busy), 64'h0);
        tick(); idle_a(); #1;
        chk("rsv_busy",  64'(a_busy), 64'h80);
        chk("rsv_rbusy", 64'(a_rbusy), 64'h3);
        a_we = 2'b01; a_waddr = {5'd0, 5'd7}; a_wdata = {32'h0, 32'hA5A5A5A5};
        #1;
        chk("rel_same_rbusy", 64'(a_rbusy), BYP ? 64'h0 : 64'h3);
        chk("rel_same_busy",  64'(a_busy), 64'h80);
        tick(); idle_a(); #1;
        chk("rel_busy",  64'(a_busy), 64'h0);
        chk("rel_rdata", a_rdata, {32'hA5A5A5A5, 32'hA5A5A5A5});
        chk("rel_rbusy", 64'(a_rbusy), 64'h0);

        // Reserve beats same-cycle write release
        a_rsv = 1'b1; a_rsv_addr = 5'd9;
        a_we = 2'b01; a_waddr = {5'd0, 5'd9}; a_wdata = {32'h0, 32'h5};
        a_raddr = {5'd9, 5'd9};
        #1;
        chk("rw_same_rbusy", 64'(a_rbusy), 64'h0);
        tick(); idle_a(); #1;
        chk("rw_busy",  64'(a_busy), 64'h200);
        chk("rw_rdata", a_rdata, {32'h5, 32'h5});
        chk("rw_rbusy", 64'(a_rbusy), 64'h3);

        // Flush overrides reserve
        a_rsv = 1'b1; a_rsv_addr = 5'd10; a_flush = 1'b1;
        tick(); idle_a(); #1;
        chk("flush_busy",  64'(a_busy), 64'h0);
        chk("flush_rbusy", 64'(a_rbusy), 64'h0);

        // Read-during-write
        a_we = 2'b01; a_waddr = {5'd0, 5'd3}; a_wdata = {32'h0, 32'h1234};
        a_raddr = {5'd3, 5'd3};
        #1;
        chk("raw_same", a_rdata, BYP ? {32'h1234, 32'h1234} : 64'h0);
        tick(); idle_a(); #1;
        chk("raw_next", a_rdata, {32'h1234, 32'h1234});

        a_we = 2'b11; a_waddr = {5'd4, 5'd4}; a_wdata = {32'hBBBB, 32'hAAAA};
        a_raddr = {5'd4, 5'd4};
        #1;
        chk("byp_prio_same", a_rdata, BYP ? {32'hBBBB, 32'hBBBB} : 64'h0);
        tick(); idle_a(); #1;
        chk("byp_prio_next", a_rdata, {32'hBBBB, 32'hBBBB});

        // RV32E instance: out-of-range address ignored
        b_we = 1'b1; b_waddr = 5'd20; b_wdata = 32'hFFFF;
        b_rsv = 1'b1; b_rsv_addr = 5'd20; b_raddr = 5'd20;
        #1;
        chk("e_oor_same", 64'(b_rdata), 64'h0);
        tick(); idle_b(); #1;
        chk("e_oor_rdata", 64'(b_rdata), 64'h0);
        chk("e_oor_rbusy", 64'(b_rbusy), 64'h0);
        chk("e_oor_busy",  64'(b_busy), 64'h0);

        b_we = 1'b1; b_waddr = 5'd15; b_wdata = 32'hF15;
        b_rsv = 1'b1; b_rsv_addr = 5'd15;
        tick(); idle_b();
        b_raddr = 5'd15;
        #1;
        chk("e_top_rdata", 64'(b_rdata), 64'hF15);
        chk("e_top_busy",  64'(b_busy), 64'h8000);
        chk("e_top_rbusy", 64'(b_rbusy), 64'h1);

        // Mid-burst reset
        a_rsv = 1'b1; a_rsv_addr = 5'd12;
        tick(); idle_a(); #1;
        chk("pre_rst_busy", 64'(a_busy), 64'h1000);
        a_we = 2'b11; a_waddr = {5'd5, 5'd13}; a_wdata = {32'h99, 32'h77};
        a_rsv = 1'b1; a_rsv_addr = 5'd14;
        a_raddr = {5'd7, 5'd5};
        b_we = 1'b1; b_waddr = 5'd15; b_wdata = 32'h55;
        tick();
        chk("burst_rdata", a_rdata, {32'hA5A5A5A5, 32'h99});
        chk("burst_busy",  64'(a_busy), 64'h5000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_rdata_a", a_rdata, 64'h0);
        chk("mrst_rbusy_a", 64'(a_rbusy), 64'h0);
        chk("mrst_busy_a",  64'(a_busy), 64'h0);
        chk("mrst_rdata_b", 64'(b_rdata), 64'h0);
        chk("mrst_busy_b",  64'(b_busy), 64'h0);
        @(negedge clk);
        idle_a(); idle_b();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        a_raddr = {5'd13, 5'd5};
        #1;
        chk("post_rst_rdata", a_rdata, 64'h0);
        chk("post_rst_busy",  64'(a_busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
